// File: rtl/cpu_fpu_issue.sv
// FP issue stage: holds one operation against a variable-latency FPU and presents the result to writeback.
// Optional one-entry skid buffer, enabled by defining FPU_ISSUE_SKID_EN.
module cpu_fpu_issue (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_op,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    input  logic [31:0] i_op3,
    input  logic [4:0]  i_rd,
    input  logic        i_rd_int,
    output logic        o_fpu_request,
    output logic [4:0]  o_fpu_op,
    output logic [31:0] o_fpu_op1,
    output logic [31:0] o_fpu_op2,
    output logic [31:0] o_fpu_op3,
    input  logic        i_fpu_ready,
    input  logic [31:0] i_fpu_result,
    output logic        o_valid,
    input  logic        i_wb_ready,
    output logic [31:0] o_result,
    output logic [4:0]  o_rd,
    output logic        o_rd_int,
    input  logic        i_flush,
    output logic [31:0] o_busy_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] op3;
        logic [4:0]  rd;
        logic        rd_int;
    } req_t;

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    req_t        in_req;
    req_t        pend_req;
    logic [31:0] result_q, result_d;
    logic [31:0] busy_q, busy_d;
    logic        pend_valid;
    logic        accept;
    logic        in_flight;

    assign in_req    = {i_op, i_op1, i_op2, i_op3, i_rd, i_rd_int};
    assign accept    = i_valid & o_ready;
    assign in_flight = (state_q == ST_BUSY) | (state_q == ST_DRAIN);

`ifdef FPU_ISSUE_SKID_EN
    req_t skid_q, skid_d;
    logic skid_valid_q, skid_valid_d;
    logic skid_bypass;

    assign o_ready     = ~skid_valid_q & ~i_flush;
    assign pend_valid  = skid_valid_q & ~i_flush;
    assign pend_req    = skid_q;
    // States where an operation goes straight into the main register instead of the skid.
    assign skid_bypass = (state_q == ST_IDLE) | ((state_q == ST_DONE) & i_wb_ready);

    always_comb begin
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (i_flush) begin
            skid_valid_d = 1'b0;
        end else if (accept & ~skid_bypass) begin
            skid_d       = in_req;
            skid_valid_d = 1'b1;
        end else if (skid_valid_q & skid_bypass) begin
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign o_ready    = (state_q == ST_IDLE) & ~i_flush;
    assign pend_valid = 1'b0;
    assign pend_req   = '0;
`endif

    // NOTE: every next-state signal gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        result_d = result_q;
        busy_d   = busy_q + {31'd0, in_flight};
        case (state_q)
            ST_IDLE: begin
                if (pend_valid) begin
                    req_d   = pend_req;
                    state_d = ST_BUSY;
                end else if (accept) begin
                    req_d   = in_req;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A flush that coincides with the FPU finishing has nothing left to drain.
                if (i_flush) begin
                    state_d = i_fpu_ready ? ST_IDLE : ST_DRAIN;
                end else if (i_fpu_ready) begin
                    result_d = i_fpu_result;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_flush) begin
                    state_d = ST_IDLE;
                end else if (i_wb_ready) begin
                    if (pend_valid) begin
                        req_d   = pend_req;
                        state_d = ST_BUSY;
                    end else if (accept) begin
                        req_d   = in_req;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (i_fpu_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the payload registers are reset too, because the FPU operand and writeback ports must read zero during reset.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            result_q <= '0;
            busy_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
            state_q  <= state_d;
            req_q    <= req_d;
            result_q <= result_d;
            busy_q   <= busy_d;
        end
    end

    assign o_fpu_request = in_flight;
    assign o_fpu_op      = req_q.op;
    assign o_fpu_op1     = req_q.op1;
    assign o_fpu_op2     = req_q.op2;
    assign o_fpu_op3     = req_q.op3;
    assign o_valid       = (state_q == ST_DONE);
    assign o_result      = result_q;
    assign o_rd          = req_q.rd;
    assign o_rd_int      = req_q.rd_int;
    assign o_busy_cycles = busy_q;

endmodule

// File: tb/tb_cpu_fpu_issue.sv
// Self-checking bench for cpu_fpu_issue: directed scenarios plus randomized operations against a transaction-level model.
module tb_cpu_fpu_issue;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_MOV = 5'd9;
    localparam logic [4:0] OP_CMP = 5'd12;
`ifdef FPU_ISSUE_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  i_op;
    logic [31:0] i_op1, i_op2, i_op3;
    logic [4:0]  i_rd;
    logic        i_rd_int;
    logic        o_fpu_request;
    logic [4:0]  o_fpu_op;
    logic [31:0] o_fpu_op1, o_fpu_op2, o_fpu_op3;
    logic        i_fpu_ready;
    logic [31:0] i_fpu_result;
    logic        o_valid;
    logic        i_wb_ready;
    logic [31:0] o_result;
    logic [4:0]  o_rd;
    logic        o_rd_int;
    logic        i_flush;
    logic [31:0] o_busy_cycles;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_busy;

    cpu_fpu_issue dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_op          (i_op),
        .i_op1         (i_op1),
        .i_op2         (i_op2),
        .i_op3         (i_op3),
        .i_rd          (i_rd),
        .i_rd_int      (i_rd_int),
        .o_fpu_request (o_fpu_request),
        .o_fpu_op      (o_fpu_op),
        .o_fpu_op1     (o_fpu_op1),
        .o_fpu_op2     (o_fpu_op2),
        .o_fpu_op3     (o_fpu_op3),
        .i_fpu_ready   (i_fpu_ready),
        .i_fpu_result  (i_fpu_result),
        .o_valid       (o_valid),
        .i_wb_ready    (i_wb_ready),
        .o_result      (o_result),
        .o_rd          (o_rd),
        .o_rd_int      (o_rd_int),
        .i_flush       (i_flush),
        .o_busy_cycles (o_busy_cycles)
    );

    always #5 i_clock = ~i_clock;

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic quiet_inputs();
        i_valid      = 1'b0;
        i_flush      = 1'b0;
        i_fpu_ready  = 1'b0;
        i_wb_ready   = 1'b0;
        i_op         = 5'($urandom);
        i_op1        = $urandom;
        i_op2        = $urandom;
        i_op3        = $urandom;
        i_rd         = 5'($urandom);
        i_rd_int     = 1'($urandom);
        i_fpu_result = $urandom;
    endtask

    task automatic offer(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [4:0] rd, input logic rd_int);
        i_valid  = 1'b1;
        i_op     = op;
        i_op1    = a;
        i_op2    = b;
        i_op3    = c;
        i_rd     = rd;
        i_rd_int = rd_int;
    endtask

    // One complete operation: accept, lat extra FPU wait cycles, wb_wait stalled writeback cycles.
    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c, input logic [31:0] res,
                          input logic [4:0] rd, input logic rd_int, input int lat,
                          input int wb_wait, input bit flush_done);
        offer(op, a, b, c, rd, rd_int);
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: o_ready=%b want 1", name, o_ready);
        end
        tick();
        quiet_inputs();
        for (int k = 0; k <= lat; k++) begin
            checks++;
            if ({o_fpu_request, o_valid, o_ready} !== {1'b1, 1'b0, SKID}) begin
                errors++;
                $display("FAIL %s busy ctl[%0d]: req/valid/ready=%b want %b", name, k,
                         {o_fpu_request, o_valid, o_ready}, {1'b1, 1'b0, SKID});
            end
            checks++;
            if ({o_fpu_op, o_fpu_op1, o_fpu_op2, o_fpu_op3} !== {op, a, b, c}) begin
                errors++;
                $display("FAIL %s operands[%0d]: got %h want %h", name, k,
                         {o_fpu_op, o_fpu_op1, o_fpu_op2, o_fpu_op3}, {op, a, b, c});
            end
            if (k == lat) begin
                i_fpu_ready  = 1'b1;
                i_fpu_result = res;
            end
            tick();
            i_fpu_ready  = 1'b0;
            i_fpu_result = $urandom;
        end
        exp_busy += 32'(lat + 1);
        for (int w = 0; w <= wb_wait; w++) begin
            checks++;
            if ({o_fpu_request, o_valid, o_ready} !== {1'b0, 1'b1, SKID}) begin
                errors++;
                $display("FAIL %s done ctl[%0d]: req/valid/ready=%b want %b", name, w,
                         {o_fpu_request, o_valid, o_ready}, {1'b0, 1'b1, SKID});
            end
            checks++;
            if ({o_result, o_rd, o_rd_int} !== {res, rd, rd_int}) begin
                errors++;
                $display("FAIL %s payload[%0d]: got %h want %h", name, w,
                         {o_result, o_rd, o_rd_int}, {res, rd, rd_int});
            end
            checks++;
            if (o_busy_cycles !== exp_busy) begin
                errors++;
                $display("FAIL %s busy count: got %0d want %0d", name, o_busy_cycles, exp_busy);
            end
            if (w == wb_wait) begin
                i_wb_ready = 1'b1;
                i_flush    = flush_done;
            end
            tick();
            i_wb_ready = 1'b0;
            i_flush    = 1'b0;
        end
        #1;
        checks++;
        if ({o_fpu_request, o_valid, o_ready} !== 3'b001) begin
            errors++;
            $display("FAIL %s back to idle: req/valid/ready=%b want 001", name,
                     {o_fpu_request, o_valid, o_ready});
        end
    endtask

    // Flush on the last of busy_n BUSY cycles, then the FPU finishes after drain_n cycles.
    task automatic run_flush(input string name, input int busy_n, input int drain_n);
        logic [31:0] a, b, c;
        logic [4:0]  op;
        a  = $urandom;
        b  = $urandom;
        c  = $urandom;
        op = 5'($urandom);
        offer(op, a, b, c, 5'($urandom), 1'($urandom));
        tick();
        quiet_inputs();
        for (int k = 0; k < busy_n + drain_n; k++) begin
            checks++;
            if ({o_fpu_request, o_valid} !== 2'b10) begin
                errors++;
                $display("FAIL %s req held[%0d]: req/valid=%b want 10", name, k,
                         {o_fpu_request, o_valid});
            end
            checks++;
            if ({o_fpu_op, o_fpu_op1, o_fpu_op2, o_fpu_op3} !== {op, a, b, c}) begin
                errors++;
                $display("FAIL %s operands[%0d]: got %h want %h", name, k,
                         {o_fpu_op, o_fpu_op1, o_fpu_op2, o_fpu_op3}, {op, a, b, c});
            end
            i_flush     = (k == busy_n - 1);
            i_fpu_ready = (k == busy_n + drain_n - 1);
            tick();
            i_flush     = 1'b0;
            i_fpu_ready = 1'b0;
        end
        exp_busy += 32'(busy_n + drain_n);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({o_fpu_request, o_valid, o_ready, o_busy_cycles} !== {3'b001, exp_busy}) begin
                errors++;
                $display("FAIL %s after drain[%0d]: got %h want %h", name, k,
                         {o_fpu_request, o_valid, o_ready, o_busy_cycles}, {3'b001, exp_busy});
            end
            tick();
        end
    endtask

    task automatic test_reset();
        quiet_inputs();
        i_reset = 1'b0;
        #3;
        checks++;
        if ({o_fpu_request, o_valid, o_result, o_rd, o_rd_int, o_fpu_op, o_fpu_op1,
             o_fpu_op2, o_fpu_op3, o_busy_cycles} !== '0) begin
            errors++;
            $display("FAIL reset outputs: some output nonzero (req=%b valid=%b busy=%0d)",
                     o_fpu_request, o_valid, o_busy_cycles);
        end
        @(negedge i_clock);
        i_reset = 1'b1;
        exp_busy = '0;
        tick();
        checks++;
        if ({o_fpu_request, o_valid, o_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset release: req/valid/ready=%b want 001",
                     {o_fpu_request, o_valid, o_ready});
        end
    endtask

    task automatic test_mov();
        run_op("mov", OP_MOV, 32'h3F80_0000, 32'h0, 32'h0, 32'h3F80_0000, 5'd7, 1'b0, 0, 0, 1'b0);
        checks++;
        if (o_busy_cycles !== 32'd1) begin
            errors++;
            $display("FAIL mov busy count: got %0d want 1", o_busy_cycles);
        end
    endtask

    task automatic test_add_latency();
        run_op("add6", OP_ADD, 32'h4000_0000, 32'h4040_0000, 32'h0, 32'h40A0_0000, 5'd3, 1'b0,
               5, 0, 1'b0);
    endtask

    task automatic test_wb_stall();
        run_op("wbstall", OP_ADD, $urandom, $urandom, $urandom, 32'hDEAD_BEEF, 5'd31, 1'b1,
               2, 4, 1'b0);
    endtask

    task automatic test_flush_idle();
        offer(OP_ADD, $urandom, $urandom, $urandom, 5'd1, 1'b0);
        i_flush = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush idle ready: o_ready=%b want 0", o_ready);
        end
        tick();
        quiet_inputs();
        #1;
        checks++;
        if ({o_fpu_request, o_valid, o_ready, o_busy_cycles} !== {3'b001, exp_busy}) begin
            errors++;
            $display("FAIL flush idle state: got %h want %h",
                     {o_fpu_request, o_valid, o_ready, o_busy_cycles}, {3'b001, exp_busy});
        end
    endtask

    task automatic test_flush_busy();
        run_flush("flush_busy", 1, 3);
    endtask

    task automatic test_flush_done();
        run_op("flush_done", OP_CMP, $urandom, $urandom, 32'h0, 32'h1, 5'd9, 1'b1, 1, 0, 1'b1);
        tick();
        checks++;
        if ({o_fpu_request, o_valid} !== 2'b00) begin
            errors++;
            $display("FAIL flush done stays idle: req/valid=%b want 00", {o_fpu_request, o_valid});
        end
    endtask

    task automatic test_reset_mid_busy();
        offer(OP_DIV, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 5'd21, 1'b1);
        tick();
        quiet_inputs();
        tick();
        i_reset = 1'b0;
        #1;
        checks++;
        if ({o_fpu_request, o_valid, o_result, o_rd, o_rd_int, o_fpu_op, o_fpu_op1,
             o_fpu_op2, o_fpu_op3, o_busy_cycles} !== '0) begin
            errors++;
            $display("FAIL reset mid busy: req=%b op1=%h busy=%0d want all zero",
                     o_fpu_request, o_fpu_op1, o_busy_cycles);
        end
        @(negedge i_clock);
        i_reset = 1'b1;
        exp_busy = '0;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset mid busy ready: o_ready=%b want 1", o_ready);
        end
        tick();
        checks++;
        if ({o_fpu_request, o_valid, o_busy_cycles} !== 34'd0) begin
            errors++;
            $display("FAIL reset mid busy idle: req=%b valid=%b busy=%0d", o_fpu_request,
                     o_valid, o_busy_cycles);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int kind;
            kind = $urandom_range(0, 4);
            if (kind == 4) begin
                run_flush("rand_flush", $urandom_range(1, 3), $urandom_range(1, 4));
            end else begin
                run_op("rand_op", 5'($urandom), $urandom, $urandom, $urandom, $urandom,
                       5'($urandom), 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 3),
                       kind == 3);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

`ifdef FPU_ISSUE_SKID_EN
    task automatic test_skid();
        offer(OP_DIV, 32'h4120_0000, 32'h4000_0000, 32'h0, 5'd4, 1'b0);
        tick();
        offer(OP_CMP, 32'h3F80_0000, 32'h4000_0000, 32'h0, 5'd5, 1'b1);
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL skid accept in busy: o_ready=%b want 1", o_ready);
        end
        tick();
        quiet_inputs();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({o_fpu_request, o_ready, o_fpu_op, o_fpu_op1} !== {2'b10, OP_DIV, 32'h4120_0000}) begin
                errors++;
                $display("FAIL skid div busy[%0d]: got %h", k, {o_fpu_request, o_ready, o_fpu_op, o_fpu_op1});
            end
            i_fpu_ready  = (k == 2);
            i_fpu_result = 32'h40A0_0000;
            tick();
            i_fpu_ready = 1'b0;
        end
        checks++;
        if ({o_fpu_request, o_valid, o_result, o_rd} !== {2'b01, 32'h40A0_0000, 5'd4}) begin
            errors++;
            $display("FAIL skid div done: got %h", {o_fpu_request, o_valid, o_result, o_rd});
        end
        i_wb_ready = 1'b1;
        tick();
        i_wb_ready = 1'b0;
        checks++;
        if ({o_fpu_request, o_valid, o_fpu_op, o_fpu_op1} !== {2'b10, OP_CMP, 32'h3F80_0000}) begin
            errors++;
            $display("FAIL skid cmp busy: got %h", {o_fpu_request, o_valid, o_fpu_op, o_fpu_op1});
        end
        i_fpu_ready  = 1'b1;
        i_fpu_result = 32'h1;
        tick();
        i_fpu_ready = 1'b0;
        checks++;
        if ({o_valid, o_result, o_rd, o_rd_int} !== {1'b1, 32'h1, 5'd5, 1'b1}) begin
            errors++;
            $display("FAIL skid cmp done: got %h", {o_valid, o_result, o_rd, o_rd_int});
        end
        exp_busy += 32'd5;
        i_wb_ready = 1'b1;
        tick();
        i_wb_ready = 1'b0;
        checks++;
        if ({o_fpu_request, o_valid, o_busy_cycles} !== {2'b00, exp_busy}) begin
            errors++;
            $display("FAIL skid drained: got %h want %h", {o_fpu_request, o_valid, o_busy_cycles},
                     {2'b00, exp_busy});
        end
    endtask
`endif

    initial begin
        exp_busy = '0;
        test_reset();
        test_mov();
        test_add_latency();
        test_wb_stall();
        test_flush_idle();
        test_flush_busy();
        test_flush_done();
        test_reset_mid_busy();
        test_random();
`ifdef FPU_ISSUE_SKID_EN
        test_skid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
